// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, command-master state encoding and CPU control-slave byte map.
// Pure declarations: no logic, no latency, no flow control.
package axil_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axil_resp_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_DATA,
      S_VR_REQ,
      S_VR_DATA,
      S_RSP
   } axil_state_e;

   localparam logic [7:0] CPU_CTRL   = 8'h00;
   localparam logic [7:0] CPU_STATUS = 8'h04;
   localparam logic [7:0] CPU_PC     = 8'h08;
   localparam logic [7:0] CPU_REG    = 8'h0C;
   localparam logic [7:0] CPU_INSTR  = 8'h40;
   localparam logic [7:0] CPU_DATA   = 8'h80;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite channel bundle between the command master and a control slave.
// Wires only; VALID/READY handshakes are owned by the endpoints.
interface axil_cmd_master_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  wvalid;
   logic                  wready;
   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  rvalid;
   logic                  rready;
   logic [31:0]           rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_strb_cmp.sv
// Byte-masked 32-bit compare: flags any strobed byte that differs between a_dat and b_dat.
// Combinational, zero latency, no flow control.
module axil_strb_cmp (
   input  logic [31:0] a_dat,
   input  logic [31:0] b_dat,
   input  logic [3:0]  strb,
   output logic        mismatch
);
   always_comb begin
      mismatch = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (strb[i] && (a_dat[8*i +: 8] != b_dat[8*i +: 8])) begin
            mismatch = 1'b1;
         end
      end
   end
endmodule

// File: rtl/axil_cmd_master.sv
// Valid/ready command port to single-beat AXI4-Lite read/write, one transaction in flight, one response beat each.
// Min 3 cycles cmd->rsp (more with slave stalls); rsp held until rsp_ready; AXIL_READBACK_EN adds verify read after OKAY writes.
module axil_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  M_AXI_ACLK,
   input  logic                  M_AXI_ARESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_mismatch,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  txn_count,
   output logic [CNT_WIDTH-1:0]  err_count,
   axil_cmd_master_if.master     m_axi
);
   import axil_pkg::*;

   axil_state_e           state;
   logic                  cmd_ready_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic                  rsp_valid_q;
   logic [31:0]           rsp_rdata_q;
   logic [1:0]            rsp_resp_q;
   logic [CNT_WIDTH-1:0]  txn_q, err_q;
   logic                  aw_done, w_done, rsp_err;

`ifdef AXIL_READBACK_EN
   logic rsp_mismatch_q;
   logic rb_mismatch;

   axil_strb_cmp u_strb_cmp (
      .a_dat    (wdata_q),
      .b_dat    (m_axi.rdata),
      .strb     (wstrb_q),
      .mismatch (rb_mismatch)
   );
   assign rsp_mismatch = rsp_mismatch_q;
`else
   assign rsp_mismatch = 1'b0;
`endif

   // A channel counts as done once its VALID has gone or is being accepted this edge.
   assign aw_done = !awvalid_q || m_axi.awready;
   assign w_done  = !wvalid_q  || m_axi.wready;
   assign rsp_err = (rsp_resp_q != RESP_OKAY) || rsp_mismatch;

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state       <= S_IDLE;
         cmd_ready_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         txn_q       <= '0;
         err_q       <= '0;
`ifdef AXIL_READBACK_EN
         rsp_mismatch_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= cmd_addr;
                  wdata_q     <= cmd_wdata;
                  wstrb_q     <= cmd_wstrb;
                  rsp_rdata_q <= '0;
                  rsp_resp_q  <= RESP_OKAY;
`ifdef AXIL_READBACK_EN
                  rsp_mismatch_q <= 1'b0;
`endif
                  if (cmd_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state     <= S_WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state     <= S_RD_REQ;
                  end
               end
            end
            S_WR_REQ: begin
               if (m_axi.awready) awvalid_q <= 1'b0;
               if (m_axi.wready)  wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q <= 1'b1;
                  state    <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (m_axi.bvalid) begin
                  bready_q   <= 1'b0;
                  rsp_resp_q <= m_axi.bresp;
`ifdef AXIL_READBACK_EN
                  if (m_axi.bresp == RESP_OKAY) begin
                     arvalid_q <= 1'b1;
                     state     <= S_VR_REQ;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     state       <= S_RSP;
                  end
`else
                  rsp_valid_q <= 1'b1;
                  state       <= S_RSP;
`endif
               end
            end
            S_RD_REQ: begin
               if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (m_axi.rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_rdata_q <= m_axi.rdata;
                  rsp_resp_q  <= m_axi.rresp;
                  rsp_valid_q <= 1'b1;
                  state       <= S_RSP;
               end
            end
`ifdef AXIL_READBACK_EN
            S_VR_REQ: begin
               if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= S_VR_DATA;
               end
            end
            S_VR_DATA: begin
               if (m_axi.rvalid) begin
                  rready_q       <= 1'b0;
                  rsp_rdata_q    <= m_axi.rdata;
                  rsp_resp_q     <= m_axi.rresp;
                  rsp_mismatch_q <= rb_mismatch;
                  rsp_valid_q    <= 1'b1;
                  state          <= S_RSP;
               end
            end
`endif
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state       <= S_IDLE;
                  if (txn_q != '1) txn_q <= txn_q + 1'b1;
                  if (rsp_err && (err_q != '1)) err_q <= err_q + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign busy          = (state != S_IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign txn_count     = txn_q;
   assign err_count     = err_q;

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.rready  = rready_q;
endmodule
